// File: rtl/codec_cfg_seq.sv
// Codec init-table sequencer driving the iic_com command port, plus runtime register writes.
// Define CFG_VERIFY_EN to read back and compare every init write, with bounded rewrites.
module codec_cfg_seq #(
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Cfg_Start,
  output logic       Cfg_Busy,
  output logic       Cfg_Done,
  output logic       Cfg_Err,
  input  logic       Wr_Req,
  input  logic [7:0] Wr_Addr,
  input  logic [7:0] Wr_Data,
  output logic       Wr_Ack,
  output logic [1:0] Start_Sig,
  output logic [7:0] Addr_Sig,
  output logic [7:0] WrData,
  input  logic       Done_Sig,
  input  logic [7:0] RdData,
  output logic       Iic_Rst_Req
);

  typedef enum logic [2:0] {IDLE, LOAD, WR, GAP, RD, CMP, READY, ERR} state_t;

  localparam logic [16:0] TMO_LIM  = 17'(TIMEOUT_CYC);
  localparam logic [2:0]  LAST_IDX = 3'd5;

  state_t      state_q, state_n;
  logic [2:0]  idx_q, idx_n;
  logic [16:0] tmo_q, tmo_n, tmo_inc;
  logic        rt_q, rt_n;
  logic [1:0]  start_n;
  logic [7:0]  addr_n, wdata_n;
  logic        busy_n, done_n, err_n, ack_n, rst_req_n;
  logic        advance;
  logic [7:0]  rom_addr, rom_data;

`ifdef CFG_VERIFY_EN
  logic [7:0]  retry_q, retry_n;
  logic [7:0]  rd_q, rd_n;
  logic        last_rd_q, last_rd_n;
`else
  logic        unused_rd;
  assign unused_rd = ^{RdData, MAX_RETRY};
`endif

  // Codec initialisation table
  always_comb begin
    case (idx_q)
      3'd0:    begin rom_addr = 8'h00; rom_data = 8'h01; end
      3'd1:    begin rom_addr = 8'h01; rom_data = 8'h20; end
      3'd2:    begin rom_addr = 8'h02; rom_data = 8'h80; end
      3'd3:    begin rom_addr = 8'h03; rom_data = 8'h1F; end
      3'd4:    begin rom_addr = 8'h04; rom_data = 8'h1F; end
      3'd5:    begin rom_addr = 8'h05; rom_data = 8'h03; end
      default: begin rom_addr = 8'h00; rom_data = 8'h00; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      rt_q        <= 1'b0;
      Start_Sig   <= '0;
      Addr_Sig    <= '0;
      WrData      <= '0;
      Cfg_Busy    <= 1'b0;
      Cfg_Done    <= 1'b0;
      Cfg_Err     <= 1'b0;
      Wr_Ack      <= 1'b0;
      Iic_Rst_Req <= 1'b0;
`ifdef CFG_VERIFY_EN
      retry_q     <= '0;
      rd_q        <= '0;
      last_rd_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      tmo_q       <= tmo_n;
      rt_q        <= rt_n;
      Start_Sig   <= start_n;
      Addr_Sig    <= addr_n;
      WrData      <= wdata_n;
      Cfg_Busy    <= busy_n;
      Cfg_Done    <= done_n;
      Cfg_Err     <= err_n;
      Wr_Ack      <= ack_n;
      Iic_Rst_Req <= rst_req_n;
`ifdef CFG_VERIFY_EN
      retry_q     <= retry_n;
      rd_q        <= rd_n;
      last_rd_q   <= last_rd_n;
`endif
    end
  end

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    tmo_n     = tmo_q;
    rt_n      = rt_q;
    start_n   = Start_Sig;
    addr_n    = Addr_Sig;
    wdata_n   = WrData;
    busy_n    = Cfg_Busy;
    done_n    = Cfg_Done;
    err_n     = Cfg_Err;
    ack_n     = 1'b0;
    rst_req_n = 1'b0;
    advance   = 1'b0;
    tmo_inc   = (tmo_q == '1) ? tmo_q : tmo_q + 17'd1;
`ifdef CFG_VERIFY_EN
    retry_n   = retry_q;
    rd_n      = rd_q;
    last_rd_n = last_rd_q;
`endif

    // Restart is only honoured when no init is in flight; it beats a same-cycle Wr_Req.
    if (Cfg_Start && (state_q == IDLE || state_q == READY || state_q == ERR)) begin
      idx_n   = '0;
      rt_n    = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      busy_n  = 1'b1;
      state_n = LOAD;
`ifdef CFG_VERIFY_EN
      retry_n   = '0;
      last_rd_n = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: ;

        LOAD: begin
          addr_n  = rom_addr;
          wdata_n = rom_data;
          start_n = 2'b01;
          tmo_n   = '0;
          state_n = WR;
`ifdef CFG_VERIFY_EN
          last_rd_n = 1'b0;
`endif
        end

        WR, RD: begin
          tmo_n = tmo_inc;
          if (Done_Sig) begin
            start_n = 2'b00;
            state_n = GAP;
            ack_n   = rt_q;
`ifdef CFG_VERIFY_EN
            if (state_q == RD) rd_n = RdData;
`endif
          end else if (tmo_inc == TMO_LIM) begin
            start_n   = 2'b00;
            rst_req_n = 1'b1;
            err_n     = 1'b1;
            busy_n    = 1'b0;
            rt_n      = 1'b0;
            state_n   = ERR;
          end
        end

        GAP: begin
          if (rt_q) begin
            rt_n    = 1'b0;
            state_n = READY;
          end
`ifdef CFG_VERIFY_EN
          else if (!last_rd_q) begin
            start_n   = 2'b10;
            tmo_n     = '0;
            last_rd_n = 1'b1;
            state_n   = RD;
          end else begin
            state_n = CMP;
          end
`else
          else begin
            advance = 1'b1;
          end
`endif
        end

`ifdef CFG_VERIFY_EN
        CMP: begin
          if (rd_q == rom_data) begin
            advance = 1'b1;
          end else if (32'(retry_q) < MAX_RETRY) begin
            retry_n = retry_q + 8'd1;
            state_n = LOAD;
          end else begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            state_n = ERR;
          end
        end
`endif

        READY: begin
          if (Wr_Req) begin
            addr_n  = Wr_Addr;
            wdata_n = Wr_Data;
            start_n = 2'b01;
            tmo_n   = '0;
            rt_n    = 1'b1;
            state_n = WR;
          end
        end

        ERR: ;

        default: state_n = IDLE;
      endcase

      if (advance) begin
        if (idx_q == LAST_IDX) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = READY;
        end else begin
          idx_n   = idx_q + 3'd1;
          state_n = LOAD;
        end
`ifdef CFG_VERIFY_EN
        retry_n = '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_codec_cfg_seq.sv
// Self-checking bench for codec_cfg_seq: I2C master responder/monitor, command-log model,
// vector tables for runtime writes, hand sequences for timeout/reset/restart, random phase.
`timescale 1ns/1ps
module tb_codec_cfg_seq;
  localparam int unsigned TMO = 1000;
`ifdef CFG_VERIFY_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic       CLK = 1'b0;
  logic       RST, Cfg_Start, Wr_Req, Done_Sig;
  logic [7:0] Wr_Addr, Wr_Data, RdData;
  logic       Cfg_Busy, Cfg_Done, Cfg_Err, Wr_Ack, Iic_Rst_Req;
  logic [1:0] Start_Sig;
  logic [7:0] Addr_Sig, WrData;

  always #5 CLK = ~CLK;

  codec_cfg_seq #(.TIMEOUT_CYC(TMO), .MAX_RETRY(3)) dut (
    .CLK(CLK), .RST(RST), .Cfg_Start(Cfg_Start), .Cfg_Busy(Cfg_Busy),
    .Cfg_Done(Cfg_Done), .Cfg_Err(Cfg_Err), .Wr_Req(Wr_Req), .Wr_Addr(Wr_Addr),
    .Wr_Data(Wr_Data), .Wr_Ack(Wr_Ack), .Start_Sig(Start_Sig), .Addr_Sig(Addr_Sig),
    .WrData(WrData), .Done_Sig(Done_Sig), .RdData(RdData), .Iic_Rst_Req(Iic_Rst_Req)
  );

  typedef struct packed { logic [1:0] kind; logic [7:0] addr; logic [7:0] data; } cmd_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } ent_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; int lat; } rt_vec_t;

  ent_t    tbl [6];
  rt_vec_t vecs [4];
  cmd_t    log_q [$];
  cmd_t    exp_q [$];

  int n_checks = 0, n_err = 0;
  int lat = 100, hang_at = -1, cyc = 0;
  int ack_cnt = 0, exp_acks = 0, rstreq_cnt = 0, abort_len = 0;
  int last_done_cyc = 0, done_rise_cyc = 0;
`ifdef CFG_VERIFY_EN
  logic [7:0] regs [256];
  int rd_zero_cnt = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return Cfg_Done;
      1:       return Cfg_Err;
      default: return Wr_Ack;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int w, input int limit);
    int n = 0;
    while (n < limit && !sel(w)) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
    end
  endtask

  function automatic cmd_t get_log(input int i);
    if (i < log_q.size()) return log_q[i];
    return '1;
  endfunction

  function automatic cmd_t wr_cmd(input int i);
    return {2'b01, tbl[i].addr, tbl[i].data};
  endfunction

  // Expected traffic for one init-table entry: the write and, with verify, its readback.
  function automatic void push_entry(input int i);
    exp_q.push_back(wr_cmd(i));
`ifdef CFG_VERIFY_EN
    exp_q.push_back({2'b10, tbl[i].addr, tbl[i].data});
`endif
  endfunction

  function automatic void push_init();
    for (int i = 0; i < 6; i++) push_entry(i);
  endfunction

  task automatic pulse_start();
    Cfg_Start = 1'b1;
    tick();
    Cfg_Start = 1'b0;
  endtask

  task automatic runtime_write(input logic [7:0] a, input logic [7:0] d, input int l);
    int a0, b;
    a0 = ack_cnt;
    b = log_q.size();
    lat = l;
    Wr_Addr = a;
    Wr_Data = d;
    Wr_Req = 1'b1;
    wait_sig("rt_ack_wait", 2, 3000);
    Wr_Req = 1'b0;
    exp_q.push_back({2'b01, a, d});
    exp_acks++;
    tick();
    check("rt_cmd", get_log(b), {2'b01, a, d});
    check("rt_ack_once", ack_cnt - a0, 1);
    check("rt_flags", {Cfg_Done, Cfg_Busy, Cfg_Err}, 3'b100);
  endtask

  // I2C master model + protocol monitor, sampling at the falling edge.
  initial begin : responder
    logic prev_done, prev_cfg_done, active;
    int len, idle, cur_lat;
    cmd_t cur;
    active = 1'b0; prev_cfg_done = 1'b0;
    len = 0; idle = 100; cur_lat = 0; cur = '0;
    Done_Sig = 1'b0;
    RdData = 8'h00;
`ifdef CFG_VERIFY_EN
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
`endif
    forever begin
      @(negedge CLK);
      cyc++;
      prev_done = Done_Sig;
      Done_Sig = 1'b0;
      if (Wr_Ack) begin
        ack_cnt++;
        check("ack_cycle_after_done", prev_done, 1);
      end
      if (Iic_Rst_Req) rstreq_cnt++;
      if (Cfg_Done && !prev_cfg_done) done_rise_cyc = cyc;
      prev_cfg_done = Cfg_Done;
      if (prev_done && !RST) check("start_drop_after_done", Start_Sig, 2'b00);
      if (RST) begin
        active = 1'b0;
        idle = 100;
      end else if (Start_Sig == 2'b00) begin
        if (active && !prev_done) begin
          abort_len = len;
          check("abort_rst_req", Iic_Rst_Req, 1);
        end
        active = 1'b0;
        idle++;
      end else if (!active) begin
        cur = {Start_Sig, Addr_Sig, WrData};
        if (Start_Sig == 2'b01) check("idle_gap_ge2", idle >= 2, 1);
        log_q.push_back(cur);
        cur_lat = (log_q.size() - 1 == hang_at) ? 0 : lat;
        active = 1'b1;
        len = 1;
        idle = 0;
      end else begin
        len++;
        check("cmd_stable", {Start_Sig, Addr_Sig, WrData}, cur);
      end
      if (active && !RST && !prev_done && cur_lat != 0 && len == cur_lat) begin
        Done_Sig = 1'b1;
        last_done_cyc = cyc;
`ifdef CFG_VERIFY_EN
        if (cur.kind == 2'b01) regs[cur.addr] = cur.data;
        else if (cur.addr == 8'h01 && rd_zero_cnt > 0) begin
          RdData = 8'h00;
          rd_zero_cnt--;
        end else RdData = regs[cur.addr];
`endif
      end
    end
  end

  initial begin : main
    int base, a0, r0, n;
    logic [7:0] ra, rd;
    RST = 1'b1; Cfg_Start = 1'b0; Wr_Req = 1'b0; Wr_Addr = 8'h00; Wr_Data = 8'h00;
    tbl[0] = '{8'h00, 8'h01}; tbl[1] = '{8'h01, 8'h20}; tbl[2] = '{8'h02, 8'h80};
    tbl[3] = '{8'h03, 8'h1F}; tbl[4] = '{8'h04, 8'h1F}; tbl[5] = '{8'h05, 8'h03};
    vecs[0] = '{8'h10, 8'h55, 100}; vecs[1] = '{8'hA5, 8'h3C, 1};
    vecs[2] = '{8'hFF, 8'h00, 7};   vecs[3] = '{8'h00, 8'hFF, 2};

    repeat (3) tick();
    check("rst_start", Start_Sig, 2'b00);
    check("rst_addr_data", {Addr_Sig, WrData}, 16'h0000);
    check("rst_flags", {Cfg_Busy, Cfg_Done, Cfg_Err, Wr_Ack, Iic_Rst_Req}, 5'b00000);
    RST = 1'b0;
    tick();

    // Normal init, 100-cycle Done latency
    base = log_q.size();
    pulse_start();
    check("start_lat_load", {Start_Sig, Cfg_Busy}, 3'b001);
    tick();
    check("start_lat_wr", Start_Sig, 2'b01);
    push_init();
    wait_sig("init_done_wait", 0, 5000);
    check("init_flags", {Cfg_Done, Cfg_Busy, Cfg_Err}, 3'b100);
    check("done_latency", done_rise_cyc - last_done_cyc, 32'(1 + STEP));
    for (int i = 0; i < 6; i++) check("init_entry", get_log(base + i * STEP), wr_cmd(i));

    // Runtime write vectors
    for (int v = 0; v < 4; v++) runtime_write(vecs[v].addr, vecs[v].data, vecs[v].lat);

    // Cfg_Start and Wr_Req together in READY
    lat = 20; a0 = ack_cnt; base = log_q.size();
    Wr_Addr = 8'h22; Wr_Data = 8'h33; Wr_Req = 1'b1; Cfg_Start = 1'b1;
    tick();
    Cfg_Start = 1'b0; Wr_Req = 1'b0;
    check("start_wins_flags", {Cfg_Busy, Cfg_Done}, 2'b10);
    push_init();
    wait_sig("start_wins_done", 0, 5000);
    repeat (3) tick();
    check("start_wins_noack", ack_cnt - a0, 0);
    check("start_wins_entry0", get_log(base), wr_cmd(0));

    // Wr_Req held during init, plus an ignored Cfg_Start while busy
    a0 = ack_cnt; base = log_q.size();
    pulse_start();
    Wr_Addr = 8'h10; Wr_Data = 8'h55; Wr_Req = 1'b1;
    repeat (50) tick();
    pulse_start();
    check("pending_noack", ack_cnt - a0, 0);
    wait_sig("pending_ack_wait", 2, 5000);
    check("pending_ack_after_done", Cfg_Done, 1);
    Wr_Req = 1'b0;
    push_init();
    exp_q.push_back({2'b01, 8'h10, 8'h55});
    exp_acks++;
    tick();
    check("busy_restart_ignored", log_q.size() - base, 32'(6 * STEP + 1));

    // Timeout on entry 2
    base = log_q.size(); r0 = rstreq_cnt; abort_len = 0;
    hang_at = base + 2 * STEP;
    pulse_start();
    wait_sig("tmo_err_wait", 1, 5000);
    hang_at = -1;
    repeat (3) tick();
    check("tmo_len", abort_len, TMO);
    check("tmo_rst_req_pulses", rstreq_cnt - r0, 1);
    check("tmo_flags", {Cfg_Err, Cfg_Busy, Cfg_Done}, 3'b100);
    check("tmo_start_idle", Start_Sig, 2'b00);
    push_entry(0); push_entry(1); exp_q.push_back(wr_cmd(2));
    base = log_q.size();
    pulse_start();
    push_init();
    wait_sig("tmo_restart_done", 0, 5000);
    check("tmo_restart_entry0", get_log(base), wr_cmd(0));
    check("tmo_restart_flags", {Cfg_Done, Cfg_Err}, 2'b10);

    // Reset during the write of entry 3
    base = log_q.size();
    pulse_start();
    n = 0;
    while (log_q.size() <= base + 3 * STEP && n < 5000) begin tick(); n++; end
    check("rst_mid_reached", n < 5000, 1);
    RST = 1'b1;
    tick();
    check("rst_mid_outputs", {Start_Sig, Addr_Sig, WrData, Cfg_Busy, Cfg_Done, Cfg_Err, Wr_Ack, Iic_Rst_Req}, 0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) push_entry(i);
    exp_q.push_back(wr_cmd(3));
    tick();
    base = log_q.size();
    pulse_start();
    push_init();
    wait_sig("rst_mid_restart_done", 0, 5000);
    check("rst_mid_restart_entry0", get_log(base), wr_cmd(0));

    // Randomized runtime traffic with occasional re-inits
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        lat = $urandom_range(1, 15);
        pulse_start();
        push_init();
        wait_sig("rand_init_done", 0, 5000);
      end else begin
        ra = 8'($urandom);
        rd = 8'($urandom);
        repeat ($urandom_range(0, 5)) tick();
        runtime_write(ra, rd, $urandom_range(1, 30));
      end
    end

`ifdef CFG_VERIFY_EN
    // One bad readback of entry 1, then good
    lat = 10; rd_zero_cnt = 1;
    pulse_start();
    push_entry(0); push_entry(1); push_entry(1);
    for (int i = 2; i < 6; i++) push_entry(i);
    wait_sig("vfy_retry_done", 0, 5000);
    check("vfy_retry_flags", {Cfg_Done, Cfg_Err}, 2'b10);
    // Entry 1 never reads back
    rd_zero_cnt = 1000; base = log_q.size();
    pulse_start();
    push_entry(0);
    for (int i = 0; i < 4; i++) push_entry(1);
    wait_sig("vfy_fail_err", 1, 5000);
    check("vfy_fail_flags", {Cfg_Err, Cfg_Done, Cfg_Busy}, 3'b100);
    n = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i] == wr_cmd(1)) n++;
    check("vfy_fail_writes", n, 4);
    rd_zero_cnt = 0;
`endif

    repeat (5) tick();
    check("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check("log_entry", get_log(i), exp_q[i]);
    check("ack_total", ack_cnt, exp_acks);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
